oam_dma: RTL and testbench

- Sprite DMA engine on the CPU-side memory bus, directly upstream of the memory wrapper that decodes internal RAM and PRG ROM.
- A CPU write to $4014 launches it. It then halts the CPU and drives the wrapper bus itself (cs, rd, wr, addr).
- It copies 256 bytes from page {N,8'h00}..{N,8'hFF} into PPU OAM through repeated writes to $2004.
- Cycle timing matches 2A03 OAM DMA: 513 or 514 CPU cycles.

---
 rtl/oam_dma_pkg.sv | 17 +
 rtl/oam_dma_if.sv | 40 ++++
 rtl/oam_dma.sv | 108 ++++++++++
 tb/tb_oam_dma.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the sprite OAM DMA engine.
package oam_dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR_C  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_C = 16'h2004;
    localparam int          DMA_BYTES       = 256;
    localparam logic [7:0]  DMA_LAST_IDX    = 8'(DMA_BYTES - 1);

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side bus between the CPU, the OAM DMA engine and the memory wrapper.
// OAM_DMA_DIRECT_EN adds a dedicated OAM write port (oam_we/oam_waddr/oam_wdata).
interface oam_dma_if;

    logic [15:0] cpu_addr;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic        cpu_halt;
    logic        dma_active;
    logic        dma_cs;
    logic        dma_rd;
    logic        dma_wr;
    logic [15:0] dma_addr;
    logic [7:0]  dma_dout;
    logic [7:0]  bus_din;
`ifdef OAM_DMA_DIRECT_EN
    logic        oam_we;
    logic [7:0]  oam_waddr;
    logic [7:0]  oam_wdata;
`endif

    // No valid/ready here: the bus is strobe based. A read is dma_cs=0 with dma_rd=1 and
    // bus_din answers one clk later; a write is dma_wr=1 with dma_addr/dma_dout stable.
    modport master (
        input  cpu_addr, cpu_wr, cpu_dout, bus_din,
        output cpu_halt, dma_active, dma_cs, dma_rd, dma_wr, dma_addr, dma_dout
`ifdef OAM_DMA_DIRECT_EN
        , output oam_we, oam_waddr, oam_wdata
`endif
    );

    modport slave (
        output cpu_addr, cpu_wr, cpu_dout, bus_din,
        input  cpu_halt, dma_active, dma_cs, dma_rd, dma_wr, dma_addr, dma_dout
`ifdef OAM_DMA_DIRECT_EN
        , input oam_we, oam_waddr, oam_wdata
`endif
    );

endinterface

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a $4014 write copies page {N,00}..{N,FF} into OAM with 2A03 cycle timing.
// Build option OAM_DMA_DIRECT_EN writes OAM through oam_* instead of bus writes to $2004.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_C,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    oam_dma_if.master   bus,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] ST_IDLE  = 3'(IDLE);
    localparam logic [2:0] ST_HALT  = 3'(HALT);
    localparam logic [2:0] ST_ALIGN = 3'(ALIGN);
    localparam logic [2:0] ST_READ  = 3'(READ);
    localparam logic [2:0] ST_WRITE = 3'(WRITE);

    logic [2:0] state;
    logic       parity;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data_hold;
    logic       first_clk;

    assign state_dbg = state;

    // first_clk marks the single clk after entering WRITE: bus_din is only valid then,
    // so it is captured into data_hold regardless of ce.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            parity    <= 1'b0;
            page      <= 8'h00;
            idx       <= 8'h00;
            data_hold <= 8'h00;
            first_clk <= 1'b0;
        end else begin
            if (first_clk) begin
                data_hold <= bus.bus_din;
                first_clk <= 1'b0;
            end
            if (ce) begin
                parity <= ~parity;
                case (state)
                    ST_IDLE: begin
                        if (bus.cpu_wr && (bus.cpu_addr == DMA_REG_ADDR)) begin
                            page  <= bus.cpu_dout;
                            idx   <= 8'h00;
                            state <= ST_HALT;
                        end
                    end
                    ST_HALT:  state <= parity ? ST_ALIGN : ST_READ;
                    ST_ALIGN: state <= ST_READ;
                    ST_READ: begin
                        state     <= ST_WRITE;
                        first_clk <= 1'b1;
                    end
                    ST_WRITE: begin
                        if (idx == DMA_LAST_IDX) begin
                            idx   <= 8'h00;
                            state <= ST_IDLE;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= ST_READ;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        bus.cpu_halt   = (state != ST_IDLE);
        bus.dma_active = (state != ST_IDLE);
        bus.dma_cs     = 1'b1;
        bus.dma_rd     = 1'b0;
        bus.dma_wr     = 1'b0;
        bus.dma_addr   = 16'h0000;
        bus.dma_dout   = 8'h00;
        case (state)
            ST_READ: begin
                bus.dma_cs   = 1'b0;
                bus.dma_rd   = 1'b1;
                bus.dma_addr = {page, idx};
            end
            ST_WRITE: begin
                bus.dma_dout = first_clk ? bus.bus_din : data_hold;
`ifndef OAM_DMA_DIRECT_EN
                bus.dma_wr   = 1'b1;
                bus.dma_addr = OAM_DATA_ADDR;
`endif
            end
            default: ;
        endcase
    end

`ifdef OAM_DMA_DIRECT_EN
    assign bus.oam_we    = (state == ST_WRITE) && first_clk;
    assign bus.oam_waddr = idx;
    assign bus.oam_wdata = bus.dma_dout;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: memory model, scoreboard of expected OAM bytes, halt-length checks.
module tb_oam_dma;
  import oam_dma_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b1;
  logic [2:0] state_dbg;

  oam_dma_if bus_if();

  oam_dma dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .bus       (bus_if.master),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [0:65535];
  logic [7:0] exp_q[$];
  int ce_period = 1;
  int ce_cnt = 0;
  logic tb_parity;
  int halt_ce = 0;
  int halt_clks = 0;
  int n_writes = 0;
  logic [7:0] cur_exp = 8'h00;
  logic [7:0] cur_page = 8'h00;
  logic [7:0] exp_waddr = 8'h00;
  logic prev_wr = 1'b0;
  logic prev_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ce is updated shortly after posedge so it is stable at every negedge and posedge
  always @(posedge clk) begin
    #2;
    ce_cnt = (ce_cnt + 1) % ce_period;
    ce = (ce_cnt == 0);
  end

  // synchronous memory wrapper: 1-clk read latency, garbage when not selected
  always @(posedge clk) begin
    if (!bus_if.dma_cs && bus_if.dma_rd) bus_if.bus_din <= mem[bus_if.dma_addr];
    else bus_if.bus_din <= 8'($urandom);
  end

  always @(posedge clk) begin
    if (!rst_n) tb_parity <= 1'b0;
    else if (ce) tb_parity <= ~tb_parity;
  end

  always @(negedge clk) begin
    if (bus_if.cpu_halt) begin
      halt_clks++;
      if (ce) halt_ce++;
    end
    if (bus_if.dma_rd) chk("rd_page", 32'(bus_if.dma_addr[15:8]), 32'(cur_page));
`ifdef OAM_DMA_DIRECT_EN
    if (bus_if.cpu_halt) chk("direct_no_dma_wr", 32'(bus_if.dma_wr), 32'(0));
    if (bus_if.oam_we) begin
      chk("we_one_clk", 32'(prev_we), 32'(0));
      chk("q_empty", 32'(exp_q.size() == 0), 32'(0));
      if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
      chk("oam_waddr", 32'(bus_if.oam_waddr), 32'(exp_waddr));
      chk("oam_wdata", 32'(bus_if.oam_wdata), 32'(cur_exp));
      exp_waddr++;
      n_writes++;
    end
    prev_we = bus_if.oam_we;
`else
    if (bus_if.dma_wr) begin
      chk("wr_addr", 32'(bus_if.dma_addr), 32'(OAM_DATA_ADDR_C));
      chk("wr_cs", 32'(bus_if.dma_cs), 32'(1));
      if (!prev_wr) begin
        chk("q_empty", 32'(exp_q.size() == 0), 32'(0));
        if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
        n_writes++;
      end
      chk("wr_data", 32'(bus_if.dma_dout), 32'(cur_exp));
    end
    prev_wr = bus_if.dma_wr;
`endif
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_halt"}, 32'(bus_if.cpu_halt), 32'(0));
    chk({tag, "_active"}, 32'(bus_if.dma_active), 32'(0));
    chk({tag, "_cs"}, 32'(bus_if.dma_cs), 32'(1));
    chk({tag, "_rd"}, 32'(bus_if.dma_rd), 32'(0));
    chk({tag, "_wr"}, 32'(bus_if.dma_wr), 32'(0));
    chk({tag, "_addr"}, 32'(bus_if.dma_addr), 32'(0));
    chk({tag, "_dout"}, 32'(bus_if.dma_dout), 32'(0));
    chk({tag, "_state"}, 32'(state_dbg), 32'(3'(IDLE)));
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic want_ce);
    int guard = 0;
    do begin @(negedge clk); guard++; end while (ce !== want_ce && guard < 20);
    #1;
    bus_if.cpu_addr = a;
    bus_if.cpu_wr   = 1'b1;
    bus_if.cpu_dout = d;
    @(posedge clk); #1;
    bus_if.cpu_wr   = 1'b0;
  endtask

  // put=1 makes the HALT cycle a put cycle; HALT's parity is the inverse of the trigger edge's
  task automatic start_copy(input logic [7:0] pg, input bit put);
    int guard = 0;
    for (int i = 0; i < 256; i++) exp_q.push_back(mem[{pg, 8'(i)}]);
    cur_page = pg; halt_ce = 0; halt_clks = 0; n_writes = 0; exp_waddr = 8'h00;
    do begin @(negedge clk); guard++; end
      while (!(ce && tb_parity == !put) && guard < 20);
    #1;
    bus_if.cpu_addr = DMA_REG_ADDR_C;
    bus_if.cpu_wr   = 1'b1;
    bus_if.cpu_dout = pg;
    @(posedge clk); #1;
    bus_if.cpu_wr   = 1'b0;
  endtask

  task automatic finish_copy(input string tag, input int exp_ce, input int exp_clks);
    int n = 0;
    while (bus_if.cpu_halt && n < exp_clks + 50) begin @(negedge clk); n++; end
    chk({tag, "_timeout"}, 32'(n >= exp_clks + 50), 32'(0));
    chk({tag, "_halt_ce"}, 32'(halt_ce), 32'(exp_ce));
    chk({tag, "_halt_clks"}, 32'(halt_clks), 32'(exp_clks));
    chk({tag, "_writes"}, 32'(n_writes), 32'(256));
    chk({tag, "_q_left"}, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic wait_writes(input int target);
    int n = 0;
    while (n_writes < target && n < 5000) begin @(negedge clk); n++; end
    chk("wait_writes_timeout", 32'(n >= 5000), 32'(0));
  endtask

  task automatic check_idle(input string tag);
    repeat (6) @(posedge clk);
    #1;
    chk({tag, "_halt"}, 32'(bus_if.cpu_halt), 32'(0));
    chk({tag, "_state"}, 32'(state_dbg), 32'(3'(IDLE)));
  endtask

  initial begin
    logic [2:0]  hold_state;
    logic [15:0] hold_addr;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i);
      mem[16'h0300 + i] = 8'hA5;
      mem[16'hFF00 + i] = 8'(i * 7 + 3);
    end
    bus_if.cpu_addr = 16'h0000;
    bus_if.cpu_wr   = 1'b0;
    bus_if.cpu_dout = 8'h00;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);

    start_copy(8'h02, 1'b0);
    finish_copy("copy_get", 513, 513);

    start_copy(8'h02, 1'b1);
    finish_copy("copy_put", 514, 514);

    start_copy(8'h02, 1'b0);
    wait_writes(10);
    cpu_write(DMA_REG_ADDR_C, 8'h05, 1'b1);
    finish_copy("retrigger", 513, 513);

    cpu_write(16'h4015, 8'h02, 1'b1);
    check_idle("wr_4015");

    ce_period = 3;
    repeat (4) @(posedge clk);
    start_copy(8'h03, 1'b0);
    wait_writes(5);
    do @(negedge clk); while (ce !== 1'b0);
    hold_state = state_dbg;
    hold_addr  = bus_if.dma_addr;
    @(posedge clk); #1;
    chk("ce0_state_hold", 32'(state_dbg), 32'(hold_state));
    chk("ce0_addr_hold", 32'(bus_if.dma_addr), 32'(hold_addr));
    finish_copy("paced", 513, 1539);

    cpu_write(DMA_REG_ADDR_C, 8'h03, 1'b0);
    check_idle("wr_ce0");
    ce_period = 1;
    repeat (4) @(posedge clk);

    start_copy(8'h02, 1'b0);
    wait_writes(100);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    start_copy(8'h00, 1'b0);
    finish_copy("after_reset", 513, 513);

    start_copy(8'hFF, 1'b1);
    finish_copy("rom_page", 514, 514);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
